// File: rtl/ysyx_24100006_axi_arbiter_if.sv
// AXI4-Lite channel bundle used for the IFU, LSU and memory-slave sides of the arbiter.
// The master modport is the side that issues requests; the slave modport answers them.
interface ysyx_24100006_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Round-robin AXI4-Lite arbiter sharing one memory slave between the IFU (read-only)
// and the LSU (read/write); the grant is held until the final response handshake.
module ysyx_24100006_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  ysyx_24100006_axi_arbiter_if.slave  ifu,
  ysyx_24100006_axi_arbiter_if.slave  lsu,
  ysyx_24100006_axi_arbiter_if.master s
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFU_RD = 2'd1;
  localparam logic [1:0] LSU_RD = 2'd2;
  localparam logic [1:0] LSU_WR = 2'd3;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_nextState;
  logic       r_lastGrant;
  logic       w_nextLastGrant;

  logic       w_reqIfu;
  logic       w_reqLsuRd;
  logic       w_reqLsuWr;
  logic       w_reqLsu;
  logic [1:0] w_lsuState;

  logic       w_ifuRd;
  logic       w_lsuRd;
  logic       w_lsuWr;

  logic [ADDR_W-1:0] w_arAddr;
  logic [ADDR_W-1:0] w_awAddr;
  logic [DATA_W-1:0] w_wData;
  logic              w_unused_ifuWrite;

  assign w_reqIfu   = ifu.arvalid;
  assign w_reqLsuRd = lsu.arvalid;
  assign w_reqLsuWr = lsu.awvalid & lsu.wvalid;
  assign w_reqLsu   = w_reqLsuRd | w_reqLsuWr;
  // An LSU read takes priority over a simultaneously pending LSU write.
  assign w_lsuState = w_reqLsuRd ? LSU_RD : LSU_WR;

  always_comb begin
    w_nextState     = r_state;
    w_nextLastGrant = r_lastGrant;
    case (r_state)
      IDLE: begin
        if (w_reqIfu && w_reqLsu) begin
          w_nextState = (r_lastGrant == GRANT_IFU) ? w_lsuState : IFU_RD;
        end else if (w_reqIfu) begin
          w_nextState = IFU_RD;
        end else if (w_reqLsu) begin
          w_nextState = w_lsuState;
        end
      end
      IFU_RD: begin
        if (s.rvalid && ifu.rready) begin
          w_nextState     = IDLE;
          w_nextLastGrant = GRANT_IFU;
        end
      end
      LSU_RD: begin
        if (s.rvalid && lsu.rready) begin
          w_nextState     = IDLE;
          w_nextLastGrant = GRANT_LSU;
        end
      end
      LSU_WR: begin
        if (s.bvalid && lsu.bready) begin
          w_nextState     = IDLE;
          w_nextLastGrant = GRANT_LSU;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= GRANT_IFU;
    end else begin
      r_state     <= w_nextState;
      r_lastGrant <= w_nextLastGrant;
    end
  end

  assign w_ifuRd = (r_state == IFU_RD);
  assign w_lsuRd = (r_state == LSU_RD);
  assign w_lsuWr = (r_state == LSU_WR);

  // Slave side: every request channel is muxed purely from the grant state.
  assign w_arAddr  = w_ifuRd ? ifu.araddr : (w_lsuRd ? lsu.araddr : '0);
  assign w_awAddr  = w_lsuWr ? lsu.awaddr : '0;
  assign w_wData   = w_lsuWr ? lsu.wdata  : '0;

  assign s.araddr  = w_arAddr;
  assign s.arvalid = (w_ifuRd & ifu.arvalid) | (w_lsuRd & lsu.arvalid);
  assign s.rready  = (w_ifuRd & ifu.rready)  | (w_lsuRd & lsu.rready);
  assign s.awaddr  = w_awAddr;
  assign s.awvalid = w_lsuWr & lsu.awvalid;
  assign s.wdata   = w_wData;
  assign s.wstrb   = w_lsuWr ? lsu.wstrb : 8'h00;
  assign s.wvalid  = w_lsuWr & lsu.wvalid;
  assign s.bready  = w_lsuWr & lsu.bready;

  assign ifu.arready = w_ifuRd & s.arready;
  assign ifu.rvalid  = w_ifuRd & s.rvalid;
  assign ifu.rdata   = s.rdata;
  assign ifu.rresp   = s.rresp;
  assign ifu.awready = 1'b0;
  assign ifu.wready  = 1'b0;
  assign ifu.bvalid  = 1'b0;
  assign ifu.bresp   = 2'b00;

  assign lsu.arready = w_lsuRd & s.arready;
  assign lsu.rvalid  = w_lsuRd & s.rvalid;
  assign lsu.rdata   = s.rdata;
  assign lsu.rresp   = s.rresp;
  assign lsu.awready = w_lsuWr & s.awready;
  assign lsu.wready  = w_lsuWr & s.wready;
  assign lsu.bvalid  = w_lsuWr & s.bvalid;
  assign lsu.bresp   = s.bresp;

  // The IFU never writes, so its write-request half of the bundle is ignored.
  assign w_unused_ifuWrite = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                               ifu.wvalid, ifu.bready};

endmodule
